// File: rtl/primitives_pkg.sv
// Shared definitions for the primitives library (sync_gen, delay):
// architecture names and the common 2-bit control state encoding.
package primitives_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } prim_state_e;

endpackage

// File: rtl/sync_gen_ctr.sv
// Phase counter for sync_gen: clears to zero, steps by one and wraps to zero
// when it reaches the terminal value; flags the terminal count combinationally.
module sync_gen_ctr #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   step,
  input  logic [COUNT_WIDTH-1:0] term,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   at_term
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  assign at_term = (count_q == term);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clear || (step && at_term)) begin
        count_d = '0;
      end else if (step) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sync_gen.sv
// Programmable periodic sync-pulse generator: arm latches the period, an
// external sync edge starts RUN, then one-cycle pulses every P enabled cycles.
module sync_gen
  import primitives_pkg::*;
#(
  parameter string BLOCK_NAME   = "sync_gen",
  parameter int    X            = 0,
  parameter int    Y            = 0,
  parameter int    DX           = 0,
  parameter int    DY           = 0,
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    COUNT_WIDTH  = 16,
  parameter int    RESYNC       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   arm,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic                   sync_in,
  output logic                   sync_out,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam bit IS_VIRTEX = (ARCHITECTURE == ARCH_VIRTEX5) ||
                             (ARCHITECTURE == ARCH_VIRTEX6);

  prim_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   sync_out_q, sync_out_d;
  logic                   ctr_clear, ctr_step, ctr_tc;
  logic [COUNT_WIDTH-1:0] ctr_count;
  logic [COUNT_WIDTH-1:0] term;

  // P=0 wraps to all-ones, giving a full 2^COUNT_WIDTH period.
  assign term = period_q - COUNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    sync_out_d = 1'b0;
    ctr_clear  = 1'b0;
    ctr_step   = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            period_d = period;
          end
        end
        ST_ARMED: begin
          if (arm) begin
            period_d = period;
          end else if (sync_in) begin
            state_d    = ST_RUN;
            sync_out_d = 1'b1;
            ctr_clear  = 1'b1;
          end
        end
        ST_RUN: begin
          if (arm) begin
            state_d   = ST_ARMED;
            period_d  = period;
            ctr_clear = 1'b1;
          end else if ((RESYNC != 0) && sync_in) begin
            sync_out_d = 1'b1;
            ctr_clear  = 1'b1;
          end else begin
            sync_out_d = ctr_tc;
            ctr_step   = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          ctr_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      sync_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      sync_out_q <= sync_out_d;
    end
  end

  // Device-specific architectures reuse the behavioral counter.
  case (IS_VIRTEX)
    1'b1: begin : g_virtex
      sync_gen_ctr #(.COUNT_WIDTH(COUNT_WIDTH)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clear   (ctr_clear),
        .step    (ctr_step),
        .term    (term),
        .count   (ctr_count),
        .at_term (ctr_tc)
      );
    end
    default: begin : g_behavioral
      sync_gen_ctr #(.COUNT_WIDTH(COUNT_WIDTH)) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clear   (ctr_clear),
        .step    (ctr_step),
        .term    (term),
        .count   (ctr_count),
        .at_term (ctr_tc)
      );
    end
  endcase

  assign sync_out = sync_out_q;
  assign armed    = (state_q == ST_ARMED);
  assign count    = ctr_count;

endmodule

// File: tb/tb_sync_gen.sv
// Directed bench for sync_gen with a 4-bit counter and resync enabled.
module tb_sync_gen;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          arm;
  logic [CW-1:0] period;
  logic          sync_in;
  logic          sync_out;
  logic          armed;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  sync_gen #(
    .ARCHITECTURE ("BEHAVIORAL"),
    .COUNT_WIDTH  (CW),
    .RESYNC       (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .arm      (arm),
    .period   (period),
    .sync_in  (sync_in),
    .sync_out (sync_out),
    .armed    (armed),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic so, input logic arm_e, input int cnt);
    check_val($sformatf("%s.sync_out", tag), 32'(sync_out), 32'(so));
    check_val($sformatf("%s.armed", tag), 32'(armed), 32'(arm_e));
    check_val($sformatf("%s.count", tag), 32'(count), 32'(cnt));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; arm = 1'b0; period = '0; sync_in = 1'b0;
    step(); step();
    check_outs("reset", 1'b0, 1'b0, 0);
    rst = 1'b0;

    // IDLE ignores sync_in
    for (int i = 0; i < 4; i++) begin
      sync_in = ~sync_in;
      step();
      check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 0);
    end
    sync_in = 1'b0;

    // Basic period 4; a period change during RUN must have no effect
    arm = 1'b1; period = 4'd4;
    step();
    check_outs("arm4", 1'b0, 1'b1, 0);
    arm = 1'b0;
    step();
    check_outs("armed_wait", 1'b0, 1'b1, 0);
    sync_in = 1'b1;
    step();
    check_outs("start4", 1'b1, 1'b0, 0);
    sync_in = 1'b0; period = 4'd7;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_outs($sformatf("p4_%0d", k), (k % 4) == 0, 1'b0, k % 4);
    end

    // Enable gating with period 3; arm is ignored while en is low
    arm = 1'b1; period = 4'd3;
    step();
    check_outs("arm3", 1'b0, 1'b1, 0);
    arm = 1'b0; sync_in = 1'b1;
    step();
    check_outs("start3", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    step();
    check_outs("p3_c1", 1'b0, 1'b0, 1);
    en = 1'b0; arm = 1'b1; period = 4'd9;
    step();
    check_outs("en_lo1", 1'b0, 1'b0, 1);
    step();
    check_outs("en_lo2", 1'b0, 1'b0, 1);
    en = 1'b1; arm = 1'b0;
    step();
    check_outs("p3_c2", 1'b0, 1'b0, 2);
    step();
    check_outs("p3_pulse", 1'b1, 1'b0, 0);

    // Priority: arm beats sync_in in ARMED, new period wins
    arm = 1'b1; period = 4'd5;
    step();
    check_outs("arm5", 1'b0, 1'b1, 0);
    period = 4'd2; sync_in = 1'b1;
    step();
    check_outs("arm_prio", 1'b0, 1'b1, 0);
    arm = 1'b0;
    step();
    check_outs("start2", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    step();
    check_outs("p2_c1", 1'b0, 1'b0, 1);
    step();
    check_outs("p2_pulse", 1'b1, 1'b0, 0);

    // Period 8 with a resync at count 2, then re-arm mid-RUN with period 2
    arm = 1'b1; period = 4'd8;
    step();
    arm = 1'b0; sync_in = 1'b1;
    step();
    check_outs("start8", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    step();
    check_outs("p8_c1", 1'b0, 1'b0, 1);
    step();
    check_outs("p8_c2", 1'b0, 1'b0, 2);
    sync_in = 1'b1;
    step();
    check_outs("resync", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_outs($sformatf("p8_%0d", k), k == 8, 1'b0, k % 8);
    end
    step(); step(); step();
    check_outs("p8_c3", 1'b0, 1'b0, 3);
    arm = 1'b1; period = 4'd2;
    step();
    check_outs("rearm", 1'b0, 1'b1, 0);
    arm = 1'b0; sync_in = 1'b1;
    step();
    check_outs("restart2", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_outs($sformatf("rp2_%0d", k), (k % 2) == 0, 1'b0, k % 2);
    end

    // Period 1: pulse on every enabled RUN cycle
    arm = 1'b1; period = 4'd1;
    step();
    arm = 1'b0; sync_in = 1'b1;
    step();
    check_outs("start1", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_outs($sformatf("p1_%0d", k), 1'b1, 1'b0, 0);
    end

    // Period 0: full 16-cycle period
    arm = 1'b1; period = 4'd0;
    step();
    arm = 1'b0; sync_in = 1'b1;
    step();
    check_outs("start0", 1'b1, 1'b0, 0);
    sync_in = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_outs($sformatf("p0_%0d", k), k == 16, 1'b0, k % 16);
    end

    // Reset mid-RUN just before a pulse is due
    for (int k = 1; k <= 15; k++) step();
    check_outs("pre_rst", 1'b0, 1'b0, 15);
    rst = 1'b1;
    step();
    check_outs("rst_run", 1'b0, 1'b0, 0);
    rst = 1'b0; sync_in = 1'b1;
    step();
    check_outs("post_rst", 1'b0, 1'b0, 0);
    sync_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
